// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, ASCII constants and
// the bit-period calculation used by every transmitter in this slice.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Integer truncation is intended: the bit period is whole clock cycles.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int baud_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serialiser. busy drops during the last cycle of a stop bit so a
// queued byte can follow with no idle gap on the line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       send,
    output logic       busy,
    output logic       tx
);

    localparam int BW = baud_width(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t      r_state;
    tx_state_t      w_next_state;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           w_tx_next;
    logic           w_bit_end;
    logic           w_accept;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_accept  = send && !busy;
    assign tx        = r_tx;

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        w_tx_next    = r_tx;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                w_tx_next = 1'b1;
                if (send) begin
                    w_next_state = ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_next_state = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_next_state = ST_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                // Last stop-bit cycle: a new byte may be taken on this edge.
                if (w_bit_end) begin
                    busy         = 1'b0;
                    w_tx_next    = send ? 1'b0 : 1'b1;
                    w_next_state = send ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_tx    <= w_tx_next;
            if (r_state == ST_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (r_state == ST_DATA && w_bit_end) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {1'b0, r_shift[7:1]};
            end
            if (w_accept) begin
                r_shift <= tx_byte;
            end
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints a byte as two uppercase ASCII hex digits (optionally followed by
// CR LF) on a UART line, feeding characters back to back into uart_tx.
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600,
    parameter int NEWLINE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       done,
    output logic       uart_tx_pin
);

    localparam int         CPB     = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] N_CHARS = (NEWLINE != 0) ? 3'd4 : 3'd2;

    logic       r_active;
    logic [2:0] r_idx;
    logic [7:0] r_data;
    logic       w_busy;
    logic       w_send;
    logic [7:0] w_char;

    // done coincides with the serialiser's final stop-bit cycle, so a start
    // seen here leaves exactly one idle cycle before the next start bit.
    always_comb begin
        w_send = r_active && !w_busy && (r_idx != N_CHARS);
        done   = r_active && !w_busy && (r_idx == N_CHARS);
        ready  = !r_active || done;
        case (r_idx)
            3'd0:    w_char = hex_ascii(r_data[7:4]);
            3'd1:    w_char = hex_ascii(r_data[3:0]);
            3'd2:    w_char = ASCII_CR;
            default: w_char = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_idx    <= 3'd0;
            r_data   <= 8'h00;
        end else if (start && ready) begin
            r_active <= 1'b1;
            r_idx    <= 3'd0;
            r_data   <= data;
        end else begin
            if (done) begin
                r_active <= 1'b0;
            end
            if (w_send) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_byte (w_char),
        .send    (w_send),
        .busy    (w_busy),
        .tx      (uart_tx_pin)
    );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: a fast instance (16 clocks/bit) for the
// functional scenarios and two default-rate instances for exact timing.
module tb_uart_hex_tx;

    localparam int CPB_F = 16;    // 1650 / 100, truncated
    localparam int CPB_D = 1250;  // 12 MHz / 9600

    logic clk = 1'b0;
    logic rst;
    logic [7:0] data_f, data_d, data_n;
    logic start_f, start_d, start_n;
    logic ready_f, ready_d, ready_n;
    logic done_f, done_d, done_n;
    logic tx_f, tx_d, tx_n;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_hex_tx #(.CLK_FREQ(1650), .BAUD_RATE(100), .NEWLINE(1)) dut_fast (
        .clk(clk), .rst(rst), .data(data_f), .start(start_f),
        .ready(ready_f), .done(done_f), .uart_tx_pin(tx_f));

    uart_hex_tx dut_def (
        .clk(clk), .rst(rst), .data(data_d), .start(start_d),
        .ready(ready_d), .done(done_d), .uart_tx_pin(tx_d));

    uart_hex_tx #(.NEWLINE(0)) dut_nl0 (
        .clk(clk), .rst(rst), .data(data_n), .start(start_n),
        .ready(ready_n), .done(done_n), .uart_tx_pin(tx_n));

    function automatic logic pin_of(input int i);
        case (i)
            0:       return tx_f;
            1:       return tx_d;
            default: return tx_n;
        endcase
    endfunction

    function automatic logic ready_of(input int i);
        case (i)
            0:       return ready_f;
            1:       return ready_d;
            default: return ready_n;
        endcase
    endfunction

    function automatic logic done_of(input int i);
        case (i)
            0:       return done_f;
            1:       return done_d;
            default: return done_n;
        endcase
    endfunction

    task automatic drive(input int i, input logic [7:0] d, input logic s);
        case (i)
            0:       begin data_f = d; start_f = s; end
            1:       begin data_d = d; start_d = s; end
            default: begin data_n = d; start_n = s; end
        endcase
    endtask

    // One-cycle start pulse; acc is the cycle stamp just after the accepting edge.
    task automatic send(input int i, input logic [7:0] d, output int acc,
                        output logic rdy_b, output logic rdy_a);
        @(negedge clk);
        rdy_b = ready_of(i);
        drive(i, d, 1'b1);
        @(negedge clk);
        drive(i, d, 1'b0);
        acc   = cyc;
        rdy_a = ready_of(i);
    endtask

    // Samples every cycle of nch frames; flags any bit not held for cpb cycles.
    task automatic rx_msg(input int i, input int nch, input int cpb,
                          output logic [31:0] chars, output int ferr, output int t_first,
                          output int done_cnt, output int done_cyc, output int rdy_err,
                          output logic rdy_last, output logic tmo);
        logic v, v0;
        bit found, first, last;
        chars = '0; ferr = 0; t_first = -1; done_cnt = 0; done_cyc = -1;
        rdy_err = 0; rdy_last = 1'b0; tmo = 1'b0; found = 0; v0 = 1'b1;
        for (int w = 0; w < 4 * cpb + 8 && !found; w++) begin
            @(negedge clk);
            if (pin_of(i) === 1'b0) found = 1;
        end
        if (!found) begin
            tmo = 1'b1;
            return;
        end
        t_first = cyc;
        first = 1;
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < cpb; j++) begin
                    if (!first) @(negedge clk);
                    first = 0;
                    v = pin_of(i);
                    last = (c == nch - 1) && (k == 9) && (j == cpb - 1);
                    if (j == 0) begin
                        v0 = v;
                        if (k == 0 && v !== 1'b0) ferr++;
                        if (k == 9 && v !== 1'b1) ferr++;
                        if (k >= 1 && k <= 8) chars[8 * c + k - 1] = v;
                    end else if (v !== v0) begin
                        ferr++;
                    end
                    if (done_of(i) === 1'b1) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                    if (last) rdy_last = ready_of(i);
                    else if (ready_of(i) !== 1'b0) rdy_err++;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (pin_of(i) !== 1'b1) begin bad++; $display("FAIL reset_pin[%0d]: got %b want 1", i, pin_of(i)); end
            if (ready_of(i) !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", i, ready_of(i)); end
            if (done_of(i) !== 1'b0) begin bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_of(i)); end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 2;
        if (ready_f !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", ready_f); end
        if (tx_f !== 1'b1) begin bad++; $display("FAIL post_reset_pin: got %b want 1", tx_f); end
    endtask

    task automatic test_hex_3a();
        int acc, ferr, t0, dn, dc, re;
        logic rb, ra, rl, tmo;
        logic [31:0] ch;
        send(0, 8'h3A, acc, rb, ra);
        rx_msg(0, 4, CPB_F, ch, ferr, t0, dn, dc, re, rl, tmo);
        total += 10;
        if (rb !== 1'b1) begin bad++; $display("FAIL 3a_ready_before: got %b want 1", rb); end
        if (ra !== 1'b0) begin bad++; $display("FAIL 3a_ready_after: got %b want 0", ra); end
        if (tmo !== 1'b0) begin bad++; $display("FAIL 3a_timeout: no start bit seen"); end
        if (t0 !== acc + 1) begin bad++; $display("FAIL 3a_start_latency: got %0d want %0d", t0 - acc, 1); end
        if (ch !== 32'h0A0D4133) begin bad++; $display("FAIL 3a_chars: got %h want 0a0d4133", ch); end
        if (ferr !== 0) begin bad++; $display("FAIL 3a_framing: got %0d errors want 0", ferr); end
        if (dn !== 1) begin bad++; $display("FAIL 3a_done_count: got %0d want 1", dn); end
        if (dc - t0 + 1 !== 40 * CPB_F) begin bad++; $display("FAIL 3a_length: got %0d want %0d", dc - t0 + 1, 40 * CPB_F); end
        if (re !== 0) begin bad++; $display("FAIL 3a_ready_busy: got %0d high cycles want 0", re); end
        if (rl !== 1'b1) begin bad++; $display("FAIL 3a_ready_at_done: got %b want 1", rl); end
        @(negedge clk);
        total += 3;
        if (done_f !== 1'b0) begin bad++; $display("FAIL 3a_done_width: got %b want 0", done_f); end
        if (ready_f !== 1'b1) begin bad++; $display("FAIL 3a_idle_ready: got %b want 1", ready_f); end
        if (tx_f !== 1'b1) begin bad++; $display("FAIL 3a_idle_pin: got %b want 1", tx_f); end
    endtask

    task automatic test_back_to_back();
        int ferr, t0, dn, dc, re, t1, dn1, dc1;
        logic rl, tmo;
        logic [31:0] ch;
        int low_cnt;
        @(negedge clk);
        drive(0, 8'h00, 1'b1);
        @(negedge clk);
        drive(0, 8'hFF, 1'b1);
        rx_msg(0, 4, CPB_F, ch, ferr, t0, dn, dc, re, rl, tmo);
        total += 4;
        if (ch !== 32'h0A0D3030) begin bad++; $display("FAIL b2b_chars0: got %h want 0a0d3030", ch); end
        if (ferr !== 0) begin bad++; $display("FAIL b2b_framing0: got %0d want 0", ferr); end
        if (dn !== 1) begin bad++; $display("FAIL b2b_done0: got %0d want 1", dn); end
        if (rl !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", rl); end
        @(negedge clk);
        drive(0, 8'hFF, 1'b0);
        total += 2;
        if (tx_f !== 1'b1) begin bad++; $display("FAIL b2b_gap_pin: got %b want 1", tx_f); end
        if (ready_f !== 1'b0) begin bad++; $display("FAIL b2b_second_accept: ready got %b want 0", ready_f); end
        dc1 = dc;
        rx_msg(0, 4, CPB_F, ch, ferr, t1, dn1, dc, re, rl, tmo);
        total += 5;
        if (t1 - dc1 - 1 !== 1) begin bad++; $display("FAIL b2b_idle_gap: got %0d cycles want 1", t1 - dc1 - 1); end
        if (ch !== 32'h0A0D4646) begin bad++; $display("FAIL b2b_chars1: got %h want 0a0d4646", ch); end
        if (ferr !== 0) begin bad++; $display("FAIL b2b_framing1: got %0d want 0", ferr); end
        if (dn1 !== 1) begin bad++; $display("FAIL b2b_done1: got %0d want 1", dn1); end
        if (dc - t1 + 1 !== 40 * CPB_F) begin bad++; $display("FAIL b2b_length1: got %0d want %0d", dc - t1 + 1, 40 * CPB_F); end
        low_cnt = 0;
        repeat (3 * CPB_F) begin
            @(negedge clk);
            if (tx_f !== 1'b1) low_cnt++;
        end
        total += 1;
        if (low_cnt !== 0) begin bad++; $display("FAIL b2b_no_third: got %0d low cycles want 0", low_cnt); end
    endtask

    task automatic test_busy_ignore();
        int acc, ferr, t0, dn, dc, re;
        logic rb, ra, rl, tmo;
        logic [31:0] ch;
        int low_cnt, rdy_lo;
        send(0, 8'h7E, acc, rb, ra);
        fork
            rx_msg(0, 4, CPB_F, ch, ferr, t0, dn, dc, re, rl, tmo);
            begin
                repeat (5 * CPB_F) @(negedge clk);
                drive(0, 8'h55, 1'b1);
                @(negedge clk);
                drive(0, 8'h55, 1'b0);
                repeat (20 * CPB_F) @(negedge clk);
                drive(0, 8'h55, 1'b1);
                @(negedge clk);
                drive(0, 8'h55, 1'b0);
            end
        join
        total += 3;
        if (ch !== 32'h0A0D4537) begin bad++; $display("FAIL busy_chars: got %h want 0a0d4537", ch); end
        if (ferr !== 0) begin bad++; $display("FAIL busy_framing: got %0d want 0", ferr); end
        if (dn !== 1) begin bad++; $display("FAIL busy_done: got %0d want 1", dn); end
        low_cnt = 0;
        rdy_lo = 0;
        repeat (3 * CPB_F) begin
            @(negedge clk);
            if (tx_f !== 1'b1) low_cnt++;
            if (ready_f !== 1'b1) rdy_lo++;
        end
        total += 2;
        if (low_cnt !== 0) begin bad++; $display("FAIL busy_extra_chars: got %0d low cycles want 0", low_cnt); end
        if (rdy_lo !== 0) begin bad++; $display("FAIL busy_extra_accept: got %0d busy cycles want 0", rdy_lo); end
    endtask

    task automatic test_reset_mid();
        int acc, target, ferr, t0, dn, dc, re, done_hits, low_cnt;
        logic rb, ra, rl, tmo;
        logic [31:0] ch;
        send(0, 8'h3A, acc, rb, ra);
        // Bit 2 of 'A' (0x41) is 0: second char, DATA state, line low.
        target = acc + 1 + 13 * CPB_F + CPB_F / 2;
        for (int w = 0; w < 1000 && cyc < target; w++) @(negedge clk);
        total += 2;
        if (cyc !== target) begin bad++; $display("FAIL rmid_reach: got cycle %0d want %0d", cyc, target); end
        if (tx_f !== 1'b0) begin bad++; $display("FAIL rmid_pre_pin: got %b want 0", tx_f); end
        #2 rst = 1'b0;
        #1;
        total += 3;
        if (tx_f !== 1'b1) begin bad++; $display("FAIL rmid_async_pin: got %b want 1", tx_f); end
        if (ready_f !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", ready_f); end
        if (done_f !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done_f); end
        done_hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_f !== 1'b0) done_hits++;
        end
        rst = 1'b1;
        low_cnt = 0;
        repeat (2 * CPB_F) begin
            @(negedge clk);
            if (done_f !== 1'b0) done_hits++;
            if (tx_f !== 1'b1) low_cnt++;
        end
        total += 2;
        if (done_hits !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d done cycles want 0", done_hits); end
        if (low_cnt !== 0) begin bad++; $display("FAIL rmid_aborted: got %0d low cycles want 0", low_cnt); end
        send(0, 8'hB7, acc, rb, ra);
        rx_msg(0, 4, CPB_F, ch, ferr, t0, dn, dc, re, rl, tmo);
        total += 6;
        if (rb !== 1'b1) begin bad++; $display("FAIL rmid_restart_ready: got %b want 1", rb); end
        if (t0 !== acc + 1) begin bad++; $display("FAIL rmid_restart_latency: got %0d want 1", t0 - acc); end
        if (ch !== 32'h0A0D3742) begin bad++; $display("FAIL rmid_restart_chars: got %h want 0a0d3742", ch); end
        if (ferr !== 0) begin bad++; $display("FAIL rmid_restart_framing: got %0d want 0", ferr); end
        if (dn !== 1) begin bad++; $display("FAIL rmid_restart_done: got %0d want 1", dn); end
        if (dc - t0 + 1 !== 40 * CPB_F) begin bad++; $display("FAIL rmid_restart_length: got %0d want %0d", dc - t0 + 1, 40 * CPB_F); end
    endtask

    task automatic test_default_timing();
        int acc_d, ferr_d, t_d, dn_d, dc_d, re_d;
        int acc_n, ferr_n, t_n, dn_n, dc_n, re_n, low_n;
        logic rb_d, ra_d, rl_d, tmo_d, rb_n, ra_n, rl_n, tmo_n;
        logic [31:0] ch_d, ch_n;
        fork
            begin
                send(1, 8'h9F, acc_d, rb_d, ra_d);
                rx_msg(1, 4, CPB_D, ch_d, ferr_d, t_d, dn_d, dc_d, re_d, rl_d, tmo_d);
            end
            begin
                send(2, 8'hC4, acc_n, rb_n, ra_n);
                rx_msg(2, 2, CPB_D, ch_n, ferr_n, t_n, dn_n, dc_n, re_n, rl_n, tmo_n);
                low_n = 0;
                repeat (2 * CPB_D) begin
                    @(negedge clk);
                    if (tx_n !== 1'b1) low_n++;
                end
            end
        join
        total += 10;
        if (t_d !== acc_d + 1) begin bad++; $display("FAIL def_latency: got %0d want 1", t_d - acc_d); end
        if (ch_d !== 32'h0A0D4639) begin bad++; $display("FAIL def_chars: got %h want 0a0d4639", ch_d); end
        if (ferr_d !== 0) begin bad++; $display("FAIL def_bit_width: got %0d errors want 0", ferr_d); end
        if (dn_d !== 1) begin bad++; $display("FAIL def_done: got %0d want 1", dn_d); end
        if (dc_d - t_d + 1 !== 50000) begin bad++; $display("FAIL def_length: got %0d want 50000", dc_d - t_d + 1); end
        if (ch_n[15:0] !== 16'h3443) begin bad++; $display("FAIL nl0_chars: got %h want 3443", ch_n[15:0]); end
        if (ferr_n !== 0) begin bad++; $display("FAIL nl0_bit_width: got %0d errors want 0", ferr_n); end
        if (dn_n !== 1) begin bad++; $display("FAIL nl0_done: got %0d want 1", dn_n); end
        if (dc_n - t_n + 1 !== 25000) begin bad++; $display("FAIL nl0_length: got %0d want 25000", dc_n - t_n + 1); end
        if (low_n !== 0) begin bad++; $display("FAIL nl0_no_newline: got %0d low cycles want 0", low_n); end
    endtask

    initial begin
        rst = 1'b0;
        data_f = 8'h00; data_d = 8'h00; data_n = 8'h00;
        start_f = 1'b0; start_d = 1'b0; start_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_hex_3a();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_default_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
